// File: rtl/segment_register_bank.sv
// segment_register_bank: NUM_REGS x WIDTH register bank.
// Features:
//   - NUM_RD registered read ports, each with a per-byte write bypass.
//   - Byte-enabled architectural writes.
//   - A combinational fixed-index tap (the CS view).
//   - A dump/load sequencer that streams the whole bank out and back in
//     over valid/ready handshakes.
module segment_register_bank #(
   parameter int WIDTH     = 16,
   parameter int NUM_REGS  = 4,
   parameter int NUM_RD    = 2,
   parameter int FIXED_IDX = 1,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_RD*SEL_W-1:0] rd_sel,
   output logic [NUM_RD*WIDTH-1:0] rd_val,
   input  logic                    wr_en,
   input  logic [SEL_W-1:0]        wr_sel,
   input  logic [WIDTH/8-1:0]      wr_bytes,
   input  logic [WIDTH-1:0]        wr_val,
   output logic [WIDTH-1:0]        fixed_val,
   input  logic                    dump_start,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [SEL_W-1:0]        dump_idx,
   output logic [WIDTH-1:0]        dump_val,
   input  logic                    load_start,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [WIDTH-1:0]        load_val,
   output logic [SEL_W-1:0]        load_idx,
   output logic                    busy
);

   localparam int NBYTES = WIDTH / 8;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {IDLE, DUMP, LOAD} state_t;

   state_t                 state_q, state_d;
   logic [SEL_W-1:0]       seq_q, seq_d;
   logic [WIDTH-1:0]       regs_q [NUM_REGS];
   logic [WIDTH-1:0]       regs_d [NUM_REGS];
   logic                   load_we;

   // A load beat only lands when no arch write is pending this cycle,
   // so the two write sources never collide on the same edge.
   assign load_we = (state_q == LOAD) && load_valid && !wr_en;

   // Next-state register contents: load write first, then the arch write
   // on top so the arch write always has the final say.
   always_comb begin
      regs_d = regs_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (load_we && (seq_q == SEL_W'(r))) begin
            regs_d[r] = load_val;
         end
         if (wr_en && (wr_sel == SEL_W'(r))) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (wr_bytes[b]) begin
                  regs_d[r][b*8 +: 8] = wr_val[b*8 +: 8];
               end
            end
         end
      end
   end

   // Register storage; an out-of-range wr_sel matches no entry and is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports sample the merged next-state value.
   // This gives the per-byte arch bypass and the full-word load bypass for free.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [SEL_W-1:0] sel;
         logic [WIDTH-1:0] rd_d;
         logic [WIDTH-1:0] rd_q;

         assign sel = rd_sel[gi*SEL_W +: SEL_W];

         // Index mux; an out-of-range index reads as zero.
         always_comb begin
            rd_d = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
               if (sel == SEL_W'(r)) begin
                  rd_d = regs_d[r];
               end
            end
         end

         // One-cycle registered read data.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rd_q <= '0;
            end else begin
               rd_q <= rd_d;
            end
         end

         assign rd_val[gi*WIDTH +: WIDTH] = rd_q;
      end
   endgenerate

   // CS tap straight off the register state.
   assign fixed_val = regs_q[FIXED_IDX];

   // Dump word follows the live register state, so an arch write landing
   // while the consumer stalls is reflected at the handshake.
   always_comb begin
      dump_val = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (seq_q == SEL_W'(r)) begin
            dump_val = regs_q[r];
         end
      end
   end

   // Sequencer next-state and handshake outputs.
   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      dump_valid = 1'b0;
      load_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d = DUMP;
               seq_d   = '0;
            end else if (load_start) begin
               state_d = LOAD;
               seq_d   = '0;
            end
         end
         DUMP: begin
            dump_valid = 1'b1;
            if (dump_ready) begin
               if (seq_q == LAST_IDX) begin
                  state_d = IDLE;
                  seq_d   = '0;
               end else begin
                  seq_d = seq_q + SEL_W'(1);
               end
            end
         end
         LOAD: begin
            load_ready = !wr_en;
            if (load_valid && !wr_en) begin
               if (seq_q == LAST_IDX) begin
                  state_d = IDLE;
                  seq_d   = '0;
               end else begin
                  seq_d = seq_q + SEL_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            seq_d   = '0;
         end
      endcase
   end

   // Sequencer state; reset aborts any sequence in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
      end
   end

   assign dump_idx = seq_q;
   assign load_idx = seq_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_segment_register_bank.sv
// Directed testbench for segment_register_bank (default parameters).
// It covers:
//   - reset state;
//   - byte-enabled writes with read bypass;
//   - dump with back-pressure;
//   - load with an arch-write stall;
//   - an arch write during a stalled dump;
//   - reset in the middle of a load.
module tb_segment_register_bank;

   localparam int WIDTH  = 16;
   localparam int NREGS  = 4;
   localparam int NRD    = 2;
   localparam int SEL_W  = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NRD*SEL_W-1:0]  rd_sel;
   logic [NRD*WIDTH-1:0]  rd_val;
   logic                  wr_en;
   logic [SEL_W-1:0]      wr_sel;
   logic [WIDTH/8-1:0]    wr_bytes;
   logic [WIDTH-1:0]      wr_val;
   logic [WIDTH-1:0]      fixed_val;
   logic                  dump_start;
   logic                  dump_valid;
   logic                  dump_ready;
   logic [SEL_W-1:0]      dump_idx;
   logic [WIDTH-1:0]      dump_val;
   logic                  load_start;
   logic                  load_valid;
   logic                  load_ready;
   logic [WIDTH-1:0]      load_val;
   logic [SEL_W-1:0]      load_idx;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   segment_register_bank #(
      .WIDTH(WIDTH), .NUM_REGS(NREGS), .NUM_RD(NRD), .FIXED_IDX(1)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_sel(rd_sel), .rd_val(rd_val),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_bytes(wr_bytes), .wr_val(wr_val),
      .fixed_val(fixed_val),
      .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_val(dump_val),
      .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
      .load_val(load_val), .load_idx(load_idx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arch_write(input logic [1:0] sel, input logic [15:0] val, input logic [1:0] bytes);
      wr_en = 1'b1; wr_sel = sel; wr_val = val; wr_bytes = bytes;
      tick();
      wr_en = 1'b0;
   endtask

   function automatic logic [15:0] port(input int p);
      return rd_val[p*WIDTH +: WIDTH];
   endfunction

   logic [1:0] ready_pat [5];
   int beat;

   initial begin
      reset = 1'b1;
      rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_bytes = '0; wr_val = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      load_start = 1'b0; load_valid = 1'b0; load_val = '0;
      tick(); tick();

      // ---- reset state
      check("rst_rd_val", rd_val, 0);
      check("rst_busy", busy, 0);
      check("rst_dump_valid", dump_valid, 0);
      check("rst_load_ready", load_ready, 0);
      check("rst_fixed_val", fixed_val, 0);
      reset = 1'b0;
      tick();

      // ---- write idx2 = 0x1234, read on port0
      rd_sel = {2'd0, 2'd2};
      arch_write(2'd2, 16'h1234, 2'b11);
      check("wr_bypass_p0", port(0), 16'h1234);
      tick();
      check("rd_idx2_p0", port(0), 16'h1234);
      check("fixed_after_idx2", fixed_val, 16'h0000);

      // ---- byte-enable bypass on port1
      arch_write(2'd0, 16'hAAAA, 2'b11);
      rd_sel = {2'd0, 2'd2};
      arch_write(2'd0, 16'h55CC, 2'b01);
      check("byte_bypass_p1", port(1), 16'hAACC);
      tick();
      check("byte_merge_p1", port(1), 16'hAACC);
      check("p0_still_idx2", port(0), 16'h1234);
      arch_write(2'd0, 16'h0000, 2'b00);
      tick();
      check("zero_bytes_noop", port(1), 16'hAACC);

      // ---- dump with back-pressure
      arch_write(2'd0, 16'h0001, 2'b11);
      arch_write(2'd1, 16'h0002, 2'b11);
      arch_write(2'd2, 16'h0003, 2'b11);
      arch_write(2'd3, 16'h0004, 2'b11);
      check("fixed_val_idx1", fixed_val, 16'h0002);
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      check("dump_busy", busy, 1);
      ready_pat = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
      beat = 0;
      for (int c = 0; c < 5; c++) begin
         dump_ready = ready_pat[c][0];
         #1;
         check($sformatf("dump_valid_c%0d", c), dump_valid, 1);
         check($sformatf("dump_idx_c%0d", c), dump_idx, beat);
         check($sformatf("dump_val_c%0d", c), dump_val, beat + 1);
         if (ready_pat[c][0]) beat++;
         tick();
      end
      dump_ready = 1'b0;
      check("dump_beats", beat, 4);
      check("dump_busy_drop", busy, 0);
      check("dump_valid_drop", dump_valid, 0);

      // ---- load with arch-write stall on the second beat
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_val = 16'h0010;
      #1;
      check("load_ready_b0", load_ready, 1);
      check("load_idx_b0", load_idx, 0);
      tick();
      load_val = 16'h0020;
      wr_en = 1'b1; wr_sel = 2'd3; wr_bytes = 2'b11; wr_val = 16'hFFFF;
      #1;
      check("load_stall", load_ready, 0);
      check("load_idx_stall", load_idx, 1);
      tick();
      wr_en = 1'b0;
      #1;
      check("load_resume", load_ready, 1);
      check("load_idx_resume", load_idx, 1);
      tick();
      load_val = 16'h0030;
      tick();
      load_val = 16'h0040;
      #1;
      check("load_idx_b3", load_idx, 3);
      tick();
      load_valid = 1'b0;
      check("load_busy_drop", busy, 0);
      rd_sel = {2'd1, 2'd0};
      tick();
      check("load_r0", port(0), 16'h0010);
      check("load_r1", port(1), 16'h0020);
      rd_sel = {2'd3, 2'd2};
      tick();
      check("load_r2", port(0), 16'h0030);
      check("load_r3_over_ffff", port(1), 16'h0040);

      // ---- dump stalled at seq 1, arch write lands before the handshake
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      dump_ready = 1'b1;
      #1;
      check("dump2_v0", dump_val, 16'h0010);
      tick();
      dump_ready = 1'b0;
      wr_en = 1'b1; wr_sel = 2'd1; wr_bytes = 2'b11; wr_val = 16'hBEEF;
      tick();
      wr_en = 1'b0;
      dump_ready = 1'b1;
      #1;
      check("dump2_idx1", dump_idx, 1);
      check("dump2_beef", dump_val, 16'hBEEF);
      tick();
      check("dump2_v2", dump_val, 16'h0030);
      tick();
      check("dump2_v3", dump_val, 16'h0040);
      tick();
      dump_ready = 1'b0;
      check("dump2_idle", busy, 0);

      // ---- reset in the middle of a load
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_val = 16'h0111;
      tick();
      load_val = 16'h0222;
      tick();
      load_valid = 1'b0;
      check("midload_fixed", fixed_val, 16'h0222);
      check("midload_idx", load_idx, 2);
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_load_ready", load_ready, 0);
      check("abort_load_idx", load_idx, 0);
      check("abort_fixed", fixed_val, 0);
      check("abort_rd_val", rd_val, 0);
      tick();
      reset = 1'b0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_val = 16'h0005;
      #1;
      check("restart_idx", load_idx, 0);
      check("restart_ready", load_ready, 1);
      tick();
      load_valid = 1'b0;
      rd_sel = {2'd1, 2'd0};
      tick();
      check("restart_r0", port(0), 16'h0005);
      check("restart_r1_cleared", port(1), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/segment_register_bank.md
Name: segment_register_bank

Overview:
Parametrised successor to the 4x16 segment register file. It provides N registers of W bits, multiple registered read ports with write bypass, byte-enabled writes and a combinational fixed-index tap (the CS view). A dump/load sequencer streams the whole bank out and back in over valid/ready handshakes. The microcode uses it to save and restore segment state on task switch and debug halt.

Parameters:
WIDTH, 16, register width in bits; must be a multiple of 8.
NUM_REGS, 4, number of registers; must be at least 2.
NUM_RD, 2, number of independent read ports.
FIXED_IDX, 1, index driven on fixed_val (CS).
SEL_W (localparam), $clog2(NUM_REGS), width of every index field.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
rd_sel  in  NUM_RD*SEL_W  read index, port p at bits [p*SEL_W +: SEL_W]
rd_val  out  NUM_RD*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH]
wr_en  in  1  architectural write strobe
wr_sel  in  SEL_W  write index
wr_bytes  in  WIDTH/8  byte enables for the write
wr_val  in  WIDTH  write data
fixed_val  out  WIDTH  combinational registers[FIXED_IDX]
dump_start  in  1  pulse: stream all registers out
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts dump word
dump_idx  out  SEL_W  index of current dump word
dump_val  out  WIDTH  current dump word
load_start  in  1  pulse: stream all registers in
load_valid  in  1  load word offered
load_ready  out  1  bank accepts load word
load_val  in  WIDTH  load data, written to index load_idx
load_idx  out  SEL_W  index the next load word is written to
busy  out  1  sequencer not IDLE

Behaviour:
- Reset (async): all registers 0; rd_val 0; FSM IDLE; seq counter 0; dump_valid 0, load_ready 0, busy 0.
- Arch write: on a clk edge with wr_en=1, byte b of registers[wr_sel] <= wr_val byte b if wr_bytes[b]=1, otherwise unchanged. wr_en with wr_bytes=0 is a no-op. Arch writes are accepted in every FSM state.
- Read: rd_val[p] <= merged value of registers[rd_sel[p]], one-cycle latency.
- Read bypass is per byte. When wr_en=1 and wr_sel==rd_sel[p], enabled bytes come from wr_val and the other bytes from the register. A load write in the same cycle to the same index is also bypassed (full word).
- fixed_val is purely combinational from register state and reflects a write from the cycle after the write edge.
- FSM states IDLE, DUMP, LOAD. Counter seq (SEL_W bits) drives dump_idx and load_idx.
- IDLE: dump_start -> DUMP with seq=0. load_start -> LOAD with seq=0. If both are asserted, dump wins. Starts are ignored outside IDLE.
- DUMP: dump_valid=1. dump_val = registers[seq], combinational, so it follows any arch write landing while waiting. On dump_valid && dump_ready: if seq==NUM_REGS-1, go to IDLE and clear seq; else seq+1.
- LOAD: load_ready = !wr_en. On load_valid && load_ready: registers[seq] <= load_val (full word), then advance seq as in DUMP, returning to IDLE after index NUM_REGS-1.
- An arch write always wins over a load write. The load stalls (load_ready=0) in any cycle wr_en=1, regardless of index.
- busy = (state != IDLE).
- Reset mid-sequence aborts immediately: IDLE, seq 0, registers 0. Partially loaded data is discarded.
- Out-of-range indices (NUM_REGS not a power of 2): writes are dropped, reads return 0.

Test Plan:
- Reset, then write idx2=0x1234 (bytes=11), read idx2 on port0 -> rd_val port0 = 0x1234 one cycle later; fixed_val = 0 with FIXED_IDX=1.
- Idx0=0xAAAA; write 0x55CC with bytes=01 while port1 reads idx0 the same cycle -> rd_val port1 = 0xAACC (bypass); next-cycle read = 0xAACC.
- Regs = {0x0001,0x0002,0x0003,0x0004}, dump_start, dump_ready toggled 1,0,1,1,1 -> four beats (idx,val) = (0,1),(1,2),(2,3),(3,4); busy drops the cycle after the last handshake.
- load_start, stream 0x10,0x20,0x30,0x40 with wr_en=1 (idx3=0xFFFF) on the second beat -> load_ready=0 that cycle, load resumes. Final regs = {0x10,0x20,0x30,0x40}; the load overwrites 0xFFFF.
- DUMP waiting at seq=1, arch write idx1=0xBEEF before dump_ready -> dump_val=0xBEEF at handshake.
- Reset asserted mid-LOAD after two beats -> all regs 0, busy=0, load_ready=0 immediately; a new load_start restarts at idx0.
